trig_meas_multi: RTL and testbench
==================================

Name: trig_meas_multi

Overview:
Multi-channel trigger time measurement block, the parametrised successor to the single-channel trigger TDC plus FIFO. It has NCH independent channels, and each channel measures one of two things depending on MODE:
- the START-to-STOP interval in CLK cycles, or
- a free-running timestamp at STOP.
Results are tagged with channel number and overflow flag, arbitrated round-robin into one shared single-clock FIFO, and read by the readout/VME logic. Lost events are counted rather than silently dropped.

Parameters:
NCH, 4, number of measurement channels (1..16)
TW, 8, measured time / timestamp width in bits
DEPTH_LOG2, 10, FIFO depth = 2^DEPTH_LOG2 words
(derived) CHW = max(1, clog2(NCH)); DW = 1+CHW+TW

Ports:
CLK  in  1  measurement clock; all logic on rising edge
RST  in  1  asynchronous, active-high reset
START  in  NCH  per-channel start pulse, synchronous to CLK
STOP  in  NCH  per-channel stop pulse, synchronous to CLK
ALL_CLEAR  in  1  synchronous clear of channels, FIFO, counters
MODE  in  1  0 = interval, 1 = timestamp; change only together with ALL_CLEAR
FIFO_RD  in  1  read request
FIFO_DATA  out  DW  {OVF, CH[CHW-1:0], TIME[TW-1:0]}
FIFO_EMPTY  out  1  FIFO empty
FIFO_FULL  out  1  FIFO full
FIFO_COUNT  out  DEPTH_LOG2+1  words stored
DROP_CNT  out  16  events lost, saturating

Behaviour:
- Reset (RST=1, async):
  - all channels go to IDLE;
  - FIFO pointers are 0, FIFO_EMPTY=1, FIFO_FULL=0, FIFO_COUNT=0;
  - FIFO_DATA=0, DROP_CNT=0, timestamp counter TS=0.
- ALL_CLEAR=1: same effect as reset, but synchronous. It has priority over all other inputs in that cycle.
- TS: TW-bit free-running counter, increments every cycle and wraps at 2^TW-1 to 0.
- Per-channel FSM, states IDLE, RUN, PEND:
  - IDLE, MODE=0, START=1: go to RUN, cnt=1. If STOP=1 in the same cycle, go straight to PEND with TIME=0, OVF=0.
  - IDLE, MODE=1, STOP=1: go to PEND with TIME=TS (current value), OVF=0. START is ignored in MODE=1.
  - IDLE, STOP alone in MODE=0: ignored.
  - RUN, STOP=1: go to PEND with TIME=cnt, so TIME = t_stop - t_start in cycles. Otherwise cnt increments.
  - RUN, cnt = 2^TW-1 with no STOP: go to PEND with TIME=all ones, OVF=1.
  - RUN, START=1: ignored (first start wins).
  - PEND: holds the result until granted, then returns to IDLE on the next cycle. A START (MODE=0) or STOP (MODE=1) arriving while in PEND is lost and increments DROP_CNT. Each cycle adds at most 1 to DROP_CNT (the OR over channels). DROP_CNT saturates at 0xFFFF.
- Arbiter:
  - Each cycle with FIFO_FULL=0, at most one PEND channel is granted.
  - Round-robin: the search starts at the channel after the last granted one; after reset it starts at channel 0.
  - The granted word is written to the FIFO in that same cycle.
  - When FIFO_FULL=1, no grant is made; channels stay in PEND (backpressure).
- Latency: STOP at cycle t → PEND at t+1 → FIFO write at t+1 if granted → FIFO_EMPTY=0 at t+2.
- FIFO:
  - Single clock, registered output.
  - FIFO_RD with FIFO_EMPTY=0 at cycle t: FIFO_DATA shows the oldest word from t+1 and holds it until the next accepted read.
  - Read while empty is ignored. A write to an empty FIFO plus FIFO_RD in the same cycle: the read is ignored.
  - Write attempt while full cannot happen, because the arbiter gates it. A read during full frees one slot; the next write is possible in the following cycle.
  - FIFO_COUNT tracks +1 per write and -1 per read, and is net unchanged when both happen in the same cycle.
  - FIFO_FULL = (FIFO_COUNT == 2^DEPTH_LOG2).
- Pointers wrap modulo 2^DEPTH_LOG2.

Test Plan:
1. NCH=4, TW=8, MODE=0; START[1] at t=10, STOP[1] at t=47; then read → FIFO_DATA = {0, 2'd1, 8'd37}, FIFO_EMPTY=1 after the read.
2. START[0] with no STOP → at 255 cycles after START, word {1, 2'd0, 8'hFF} is written; the channel is back in IDLE after the grant.
3. STOP on channels 0, 2 and 3 in the same cycle, last grant = 2 → write order is ch3, ch0, ch2 on three consecutive cycles; FIFO_COUNT=3.
4. MODE=1; ALL_CLEAR, then STOP[2] 100 cycles later → TIME=8'd99 (TS was 0 in the cycle after ALL_CLEAR); STOP[2] again in the PEND cycle → DROP_CNT=1.
5. Fill the FIFO to 1024 with no reads → FIFO_FULL=1, channels hold PEND, further STOPs raise DROP_CNT; one read → the next pending word is written and FIFO_COUNT=1024 again.
6. RST asserted mid-RUN and with the FIFO non-empty → all outputs at reset values immediately (async); the first measurement after release is correct.

Source files
------------

// File: rtl/trig_meas_multi.sv
// Multi-channel trigger time measurement: per-channel interval/timestamp capture,
// round-robin arbitration into a shared single-clock FIFO, saturating lost-event count.

module trig_meas_ch #(
  parameter int TW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_clr,
  input  logic          i_mode,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [TW-1:0] i_ts,
  input  logic          i_gnt,
  output logic          o_pend,
  output logic          o_ovf,
  output logic [TW-1:0] o_time,
  output logic          o_drop
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic [1:0]    r_state;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] r_time;
  logic          r_ovf;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_time  <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_time  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!i_mode && i_start) begin
            if (i_stop) begin
              r_state <= S_PEND;
              r_time  <= '0;
              r_ovf   <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_cnt   <= TW'(1);
            end
          end else if (i_mode && i_stop) begin
            r_state <= S_PEND;
            r_time  <= i_ts;
            r_ovf   <= 1'b0;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            r_state <= S_PEND;
            r_time  <= r_cnt;
            r_ovf   <= 1'b0;
          end else if (&r_cnt) begin
            // counter saturated without a stop: report overflow
            r_state <= S_PEND;
            r_time  <= '1;
            r_ovf   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        S_PEND:  if (i_gnt) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_pend = (r_state == S_PEND);
  assign o_ovf  = r_ovf;
  assign o_time = r_time;
  assign o_drop = o_pend && (i_mode ? i_stop : i_start);
endmodule

module trig_meas_multi #(
  parameter  int NCH        = 4,
  parameter  int TW         = 8,
  parameter  int DEPTH_LOG2 = 10,
  localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int DW         = 1 + CHW + TW
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NCH-1:0]        START,
  input  logic [NCH-1:0]        STOP,
  input  logic                  ALL_CLEAR,
  input  logic                  MODE,
  input  logic                  FIFO_RD,
  output logic [DW-1:0]         FIFO_DATA,
  output logic                  FIFO_EMPTY,
  output logic                  FIFO_FULL,
  output logic [DEPTH_LOG2:0]   FIFO_COUNT,
  output logic [15:0]           DROP_CNT
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [TW-1:0]           r_ts;
  logic [NCH-1:0]          w_pend;
  logic [NCH-1:0]          w_ovf;
  logic [NCH-1:0]          w_drop;
  logic [NCH-1:0][TW-1:0]  w_time;
  logic [CHW-1:0]          r_last;
  logic [CHW-1:0]          w_gnt_idx;
  logic                    w_gnt_vld;
  logic [DW-1:0]           w_wdata;
  logic                    w_wr;
  logic                    w_rd;

  logic [DW-1:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wptr;
  logic [DEPTH_LOG2-1:0]   r_rptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic [DW-1:0]           r_rdata;
  logic [15:0]             r_drop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            r_ts <= '0;
    else if (ALL_CLEAR) r_ts <= '0;
    else                r_ts <= r_ts + TW'(1);
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    trig_meas_ch #(.TW(TW)) u_ch (
      .CLK    (CLK),
      .RST    (RST),
      .i_clr  (ALL_CLEAR),
      .i_mode (MODE),
      .i_start(START[g]),
      .i_stop (STOP[g]),
      .i_ts   (r_ts),
      .i_gnt  (w_gnt_vld && (w_gnt_idx == CHW'(g))),
      .o_pend (w_pend[g]),
      .o_ovf  (w_ovf[g]),
      .o_time (w_time[g]),
      .o_drop (w_drop[g])
    );
  end

  // round-robin search begins one past the last granted channel
  always_comb begin
    logic [CHW-1:0] idx;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    idx       = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = CHW'((int'(r_last) + 1 + k) % NCH);
      if (!w_gnt_vld && w_pend[idx] && !FIFO_FULL) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = idx;
      end
    end
  end

  assign w_wdata = {w_ovf[w_gnt_idx], w_gnt_idx, w_time[w_gnt_idx]};
  assign w_wr    = w_gnt_vld && !ALL_CLEAR;
  assign w_rd    = FIFO_RD && !FIFO_EMPTY && !ALL_CLEAR;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            r_last <= CHW'(NCH - 1);
    else if (ALL_CLEAR) r_last <= CHW'(NCH - 1);
    else if (w_wr)      r_last <= w_gnt_idx;
  end

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wptr] <= w_wdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else if (ALL_CLEAR) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_rd) begin
        r_rptr  <= r_rptr + DEPTH_LOG2'(1);
        r_rdata <= r_mem[r_rptr];
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          r_drop <= '0;
    else if (ALL_CLEAR)               r_drop <= '0;
    else if (|w_drop && r_drop != '1) r_drop <= r_drop + 16'd1;
  end

  assign FIFO_DATA  = r_rdata;
  assign FIFO_EMPTY = (r_count == '0);
  assign FIFO_FULL  = r_count[DEPTH_LOG2];
  assign FIFO_COUNT = r_count;
  assign DROP_CNT   = r_drop;
endmodule

// File: tb/tb_trig_meas_multi.sv
// Scoreboard bench for trig_meas_multi: expected words queued at stimulus, compared on read.

module tb_trig_meas_multi;
  logic        CLK = 1'b0;
  logic        RST, ALL_CLEAR, MODE, FIFO_RD;
  logic [3:0]  START, STOP;
  logic [10:0] FIFO_DATA;
  logic        FIFO_EMPTY, FIFO_FULL;
  logic [10:0] FIFO_COUNT;
  logic [15:0] DROP_CNT;

  int total = 0;
  int bad   = 0;
  int tsm;
  logic [10:0] sb[$];

  always #5 CLK = ~CLK;

  trig_meas_multi dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .ALL_CLEAR(ALL_CLEAR),
    .MODE(MODE), .FIFO_RD(FIFO_RD), .FIFO_DATA(FIFO_DATA), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_FULL(FIFO_FULL), .FIFO_COUNT(FIFO_COUNT), .DROP_CNT(DROP_CNT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock; the bench tracks the free-running timestamp alongside
  task automatic tick();
    @(posedge CLK);
    tsm = (RST || ALL_CLEAR) ? 0 : (tsm + 1) % 256;
    #1;
  endtask

  task automatic push(input int ch, input logic ovf, input int tm);
    logic [1:0] c;
    logic [7:0] t;
    c = 2'(ch);
    t = 8'(tm);
    sb.push_back({ovf, c, t});
  endtask

  task automatic rd(input string tag);
    logic [10:0] exp;
    FIFO_RD = 1'b1;
    tick();
    FIFO_RD = 1'b0;
    chk({tag, "_sbq"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk(tag, FIFO_DATA, exp);
    end
  endtask

  task automatic clear();
    ALL_CLEAR = 1'b1;
    tick();
    ALL_CLEAR = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tm;
    int guard;
    RST = 1'b1; ALL_CLEAR = 1'b0; MODE = 1'b0; FIFO_RD = 1'b0;
    START = '0; STOP = '0; tsm = 0;
    #12;
    chk("rst_empty", FIFO_EMPTY, 1);
    chk("rst_full",  FIFO_FULL, 0);
    chk("rst_count", FIFO_COUNT, 0);
    chk("rst_data",  FIFO_DATA, 0);
    chk("rst_drop",  DROP_CNT, 0);
    RST = 1'b0;
    tick();

    // interval of 37 cycles on channel 1
    START = 4'b0010; tick(); START = '0;
    repeat (36) tick();
    STOP = 4'b0010; push(1, 0, 37); tick(); STOP = '0;
    chk("t1_lat_empty", FIFO_EMPTY, 1);
    tick();
    chk("t1_empty", FIFO_EMPTY, 0);
    chk("t1_count", FIFO_COUNT, 1);
    rd("t1_data");
    chk("t1_empty_after", FIFO_EMPTY, 1);

    // overflow on channel 0, then channel back in IDLE
    START = 4'b0001; tick(); START = '0;
    push(0, 1, 255);
    repeat (255) tick();
    chk("t2_before", FIFO_EMPTY, 1);
    tick();
    chk("t2_written", FIFO_EMPTY, 0);
    rd("t2_ovf");
    START = 4'b0001; tick(); START = '0;
    repeat (4) tick();
    STOP = 4'b0001; push(0, 0, 5); tick(); STOP = '0;
    tick();
    rd("t2_idle");

    // round-robin order after last grant to channel 2
    MODE = 1'b1; clear();
    repeat (3) tick();
    STOP = 4'b0100; push(2, 0, tsm); tick(); STOP = '0;
    tick();
    rd("t3_pre");
    repeat (2) tick();
    tm = tsm;
    STOP = 4'b1101; push(3, 0, tm); push(0, 0, tm); push(2, 0, tm);
    tick(); STOP = '0;
    tick(); chk("t3_cnt1", FIFO_COUNT, 1);
    tick(); chk("t3_cnt2", FIFO_COUNT, 2);
    tick(); chk("t3_cnt3", FIFO_COUNT, 3);
    rd("t3_w0"); rd("t3_w1"); rd("t3_w2");

    // timestamp 99 cycles after clear, stop during PEND is dropped
    clear();
    chk("t4_drop0", DROP_CNT, 0);
    repeat (99) tick();
    STOP = 4'b0100; push(2, 0, 99); tick();
    tick(); STOP = '0;
    chk("t4_drop1", DROP_CNT, 1);
    chk("t4_count", FIFO_COUNT, 1);
    rd("t4_data");
    repeat (3) tick();
    chk("t4_nodup", FIFO_EMPTY, 1);

    // fill to full, backpressure, drop, then drain
    clear();
    for (int i = 0; i < 1024; i++) begin
      STOP = 4'(1 << (i % 4)); push(i % 4, 0, tsm); tick();
    end
    STOP = '0; tick();
    chk("t5_full", FIFO_FULL, 1);
    chk("t5_count", FIFO_COUNT, 1024);
    tm = tsm;
    STOP = 4'hF; push(0, 0, tm); push(1, 0, tm); push(2, 0, tm); push(3, 0, tm);
    tick();
    STOP = 4'b0001; tick(); STOP = '0;
    chk("t5_drop", DROP_CNT, 1);
    repeat (3) tick();
    chk("t5_hold", FIFO_COUNT, 1024);
    rd("t5_first");
    chk("t5_freed", FIFO_COUNT, 1023);
    tick();
    chk("t5_refill", FIFO_COUNT, 1024);
    chk("t5_full2", FIFO_FULL, 1);
    guard = 0;
    while (!FIFO_EMPTY && guard < 1100) begin
      rd("t5_drain");
      guard++;
    end
    chk("t5_sb_left", sb.size(), 0);
    chk("t5_empty", FIFO_EMPTY, 1);

    // async reset mid-run with data stored
    MODE = 1'b0; clear();
    START = 4'b0101; tick(); START = '0;
    repeat (2) tick();
    STOP = 4'b0101; push(0, 0, 3); push(2, 0, 3); tick(); STOP = '0;
    START = 4'b0100; tick();
    START = 4'b0010; tick(); START = '0;
    tick();
    rd("t6_pre");
    chk("t6_pre_cnt", FIFO_COUNT, 1);
    chk("t6_pre_drop", DROP_CNT, 1);
    #2 RST = 1'b1;
    #1;
    chk("t6_empty", FIFO_EMPTY, 1);
    chk("t6_count", FIFO_COUNT, 0);
    chk("t6_data", FIFO_DATA, 0);
    chk("t6_drop", DROP_CNT, 0);
    sb.delete();
    @(posedge CLK);
    #3 RST = 1'b0;
    tsm = 0;
    START = 4'b1000; tick(); START = '0;
    repeat (19) tick();
    STOP = 4'b1000; push(3, 0, 20); tick(); STOP = '0;
    tick();
    rd("t6_post");
    repeat (300) tick();
    chk("t6_no_stray", FIFO_EMPTY, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
